// File: rtl/image_job_scheduler_pkg.sv
// Shared types for the image job scheduler: FSM state encoding, fault codes and defaults.
// Optional per-phase watchdog is enabled by defining PHASE_TIMEOUT_EN.
package image_job_scheduler_pkg;

  localparam int DEPTH_W_DEFAULT = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIST  = 3'd1,
    ST_CDF   = 3'd2,
    ST_DIV   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } sched_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_SCRATCH = 2'b01,
    FAULT_OUTPUT  = 2'b10,
    FAULT_TIMEOUT = 2'b11
  } fault_code_e;

  function automatic logic is_phase(input sched_state_e s);
    return (s == ST_HIST) || (s == ST_CDF) || (s == ST_DIV);
  endfunction

endpackage

// File: rtl/image_job_fifo.sv
// Circular job FIFO with wrap-around pointers. A pop frees a slot in the same
// cycle, so a push into a full queue is accepted when it coincides with a pop.
module image_job_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (PTR_W+1)'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
    head_data = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/image_job_scheduler.sv
// Queues image jobs and sequences histogram -> cdf -> divider with start pulses,
// phase enables and a sticky fault latch. Define PHASE_TIMEOUT_EN for the per-phase watchdog.
module image_job_scheduler
  import image_job_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int DEPTH_W        = DEPTH_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_image_pulse,
  input  logic [DEPTH_W-1:0] job_input_depth,
  input  logic               clear_fault,
  input  logic               input_mem_done,
  input  logic               scratch_mem_overflow_fault,
  input  logic               output_mem_overflow_fault,
  input  logic               histogram_computation_done,
  input  logic               cdf_done,
  input  logic               divider_done,
  output logic               histogram_start_pulse,
  output logic               cdf_start_pulse,
  output logic               divider_start_pulse,
  output logic               histogram_en,
  output logic               cdf_en,
  output logic               divider_en,
  output logic               input_mem_read_finished,
  output logic               image_done_pulse,
  output logic [DEPTH_W-1:0] active_input_mem_depth,
  output logic               busy,
  output logic               queue_full,
  output logic               job_drop_pulse,
  output logic               fault_flag,
  output logic [1:0]         fault_code,
  output logic [2:0]         dbg_state
);

  sched_state_e       state_q, state_d;
  fault_code_e        fault_code_q, fault_code_d, fault_new;
  logic               fault_flag_q, fault_flag_d;
  logic               hist_start_q, hist_start_d;
  logic               cdf_start_q, cdf_start_d;
  logic               div_start_q, div_start_d;
  logic               hist_en_q, hist_en_d;
  logic               cdf_en_q, cdf_en_d;
  logic               div_en_q, div_en_d;
  logic               rd_fin_q, rd_fin_d;
  logic               done_pulse_q, done_pulse_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;
  logic [DEPTH_W-1:0] fifo_head;
  logic               fault_any;
  fault_code_e        fault_sel;
  logic               phase_done;
  sched_state_e       phase_next;
  logic               timeout_hit;

  image_job_fifo #(
    .WIDTH (DEPTH_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .push      (new_image_pulse),
    .push_data (job_input_depth),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

`ifdef PHASE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] phase_cnt_q, phase_cnt_d;

  // Counter value is (cycles already spent in the phase); it restarts on every phase entry.
  always_comb begin
    timeout_hit = is_phase(state_q) && (phase_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    phase_cnt_d = phase_cnt_q + 1'b1;
    if ((state_d != state_q) || !is_phase(state_q)) begin
      phase_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_cnt_q <= '0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state logic. Within a phase a fault outranks the done, and the done outranks the watchdog.
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    fault_flag_d = fault_flag_q;
    fault_code_d = fault_code_q;
    fault_new    = FAULT_NONE;
    fault_any    = scratch_mem_overflow_fault || output_mem_overflow_fault;
    fault_sel    = scratch_mem_overflow_fault ? FAULT_SCRATCH : FAULT_OUTPUT;
    phase_done   = 1'b0;
    phase_next   = ST_IDLE;
    case (state_q)
      ST_HIST: begin
        phase_done = histogram_computation_done;
        phase_next = ST_CDF;
      end
      ST_CDF: begin
        phase_done = cdf_done;
        phase_next = ST_DIV;
      end
      ST_DIV: begin
        phase_done = divider_done;
        phase_next = ST_DONE;
      end
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !fault_flag_q) begin
          fifo_pop = 1'b1;
          state_d  = ST_HIST;
        end
      end
      ST_HIST, ST_CDF, ST_DIV: begin
        if (fault_any) begin
          state_d   = ST_FAULT;
          fault_new = fault_sel;
        end else if (phase_done) begin
          state_d = phase_next;
        end else if (timeout_hit) begin
          state_d   = ST_FAULT;
          fault_new = FAULT_TIMEOUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: begin
        if (clear_fault) begin
          state_d      = ST_IDLE;
          fault_flag_d = 1'b0;
          fault_code_d = FAULT_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && !fault_flag_q) begin
      fault_flag_d = 1'b1;
      fault_code_d = fault_new;
    end
  end

  // Outputs are registered off the next state so they line up with the state register.
  always_comb begin
    hist_start_d = (state_d == ST_HIST) && (state_q != ST_HIST);
    cdf_start_d  = (state_d == ST_CDF)  && (state_q != ST_CDF);
    div_start_d  = (state_d == ST_DIV)  && (state_q != ST_DIV);
    hist_en_d    = (state_d == ST_HIST);
    cdf_en_d     = (state_d == ST_CDF);
    div_en_d     = (state_d == ST_DIV);
    done_pulse_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
    drop_d       = fifo_drop;
    depth_d      = fifo_pop ? fifo_head : depth_q;
    rd_fin_d     = 1'b0;
    if ((state_q == ST_HIST) && (state_d == ST_HIST)) begin
      rd_fin_d = rd_fin_q || input_mem_done;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fault_flag_q <= 1'b0;
      fault_code_q <= FAULT_NONE;
      hist_start_q <= 1'b0;
      cdf_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      hist_en_q    <= 1'b0;
      cdf_en_q     <= 1'b0;
      div_en_q     <= 1'b0;
      rd_fin_q     <= 1'b0;
      done_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
      depth_q      <= '0;
    end else begin
      state_q      <= state_d;
      fault_flag_q <= fault_flag_d;
      fault_code_q <= fault_code_d;
      hist_start_q <= hist_start_d;
      cdf_start_q  <= cdf_start_d;
      div_start_q  <= div_start_d;
      hist_en_q    <= hist_en_d;
      cdf_en_q     <= cdf_en_d;
      div_en_q     <= div_en_d;
      rd_fin_q     <= rd_fin_d;
      done_pulse_q <= done_pulse_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
      depth_q      <= depth_d;
    end
  end

  assign histogram_start_pulse   = hist_start_q;
  assign cdf_start_pulse         = cdf_start_q;
  assign divider_start_pulse     = div_start_q;
  assign histogram_en            = hist_en_q;
  assign cdf_en                  = cdf_en_q;
  assign divider_en              = div_en_q;
  assign input_mem_read_finished = rd_fin_q;
  assign image_done_pulse        = done_pulse_q;
  assign active_input_mem_depth  = depth_q;
  assign busy                    = busy_q;
  assign queue_full              = fifo_full;
  assign job_drop_pulse          = drop_q;
  assign fault_flag              = fault_flag_q;
  assign fault_code              = fault_code_q;
  assign dbg_state               = state_q;

endmodule
